// File: rtl/proc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : proc_pkg
// Purpose  : Shared widths, fetch-state encoding and PC reset address.
// Revision : 1.0 - initial release
// ============================================================================
package proc_pkg;

  localparam int c_ADDR_W = 16;
  localparam int c_DATA_W = 16;

  localparam logic [c_ADDR_W-1:0] c_PC_RESET_ADDR = 16'h0004;

  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_FETCH = 3'd1;
  localparam logic [2:0] c_ST_HOLD  = 3'd2;
  localparam logic [2:0] c_ST_REDIR = 3'd3;
  localparam logic [2:0] c_ST_ERR   = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = c_ST_IDLE,
    FETCH = c_ST_FETCH,
    HOLD  = c_ST_HOLD,
    REDIR = c_ST_REDIR,
    ERR   = c_ST_ERR
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_if
// Purpose  : PC, instruction-memory, decoder and branch signals of the fetch unit.
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_unit_if #(
  parameter int ADDR_W = proc_pkg::c_ADDR_W,
  parameter int DATA_W = proc_pkg::c_DATA_W
);

  logic [ADDR_W-1:0] pc_in;
  logic              incr_pc;
  logic              load;
  logic [ADDR_W-1:0] load_addr;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] ir;
  logic              ir_valid;
  logic              ir_ready;
  logic              branch_req;
  logic [ADDR_W-1:0] branch_target;
  logic              fetch_err;

  modport master (
    input  pc_in, mem_ack, mem_rdata, ir_ready, branch_req, branch_target,
    output incr_pc, load, load_addr, mem_req, mem_addr, ir, ir_valid, fetch_err
  );

  modport slave (
    output pc_in, mem_ack, mem_rdata, ir_ready, branch_req, branch_target,
    input  incr_pc, load, load_addr, mem_req, mem_addr, ir, ir_valid, fetch_err
  );

endinterface
`default_nettype wire

// File: rtl/fetch_unit_timeout.sv
`default_nettype none
// ============================================================================
// Module   : fetch_timeout
// Purpose  : Saturating wait counter; flags the last permitted wait cycle.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_timeout #(
  parameter int MAX_WAIT = 15
) (
  input  logic clock,
  input  logic resetN,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clock) begin
    if (!resetN || i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != CNT_W'(MAX_WAIT))) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // High when one more unacknowledged cycle brings the count to MAX_WAIT.
  assign o_expired = (r_count >= CNT_W'(MAX_WAIT - 1));

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Fetch controller: PC -> memory req/ack -> IR valid/ready, with redirect.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit
  import proc_pkg::*;
#(
  parameter int ADDR_W   = c_ADDR_W,
  parameter int DATA_W   = c_DATA_W,
  parameter int MAX_WAIT = 15
) (
  input  logic         clock,
  input  logic         resetN,
  fetch_unit_if.master bus
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;

  logic              w_to_fetch;
  logic              w_accept;
  logic              w_redirect;
  logic              w_timeout;
  logic              w_cnt_en;
  logic              w_expired;
  logic [ADDR_W-1:0] w_redir_target;

  logic              r_incr_pc;
  logic              r_load;
  logic [ADDR_W-1:0] r_load_addr;
  logic              r_mem_req;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_ir;
  logic              r_ir_valid;
  logic              r_fetch_err;
  logic              r_pending;
  logic [ADDR_W-1:0] r_pend_target;

  fetch_timeout #(
    .MAX_WAIT (MAX_WAIT)
  ) u_timeout (
    .clock     (clock),
    .resetN    (resetN),
    .i_clear   (w_to_fetch),
    .i_enable  (w_cnt_en),
    .o_expired (w_expired)
  );

  always_ff @(posedge clock) begin
    if (!resetN) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_to_fetch     = 1'b0;
    w_accept       = 1'b0;
    w_redirect     = 1'b0;
    w_timeout      = 1'b0;
    w_cnt_en       = 1'b0;
    w_redir_target = bus.branch_target;
    case (r_state)
      IDLE: begin
        if (bus.branch_req) begin
          w_redirect  = 1'b1;
          w_state_nxt = REDIR;
        end else begin
          w_to_fetch  = 1'b1;
          w_state_nxt = FETCH;
        end
      end
      FETCH: begin
        // The outstanding request always completes; a branch seen on the ack edge still wins.
        if (bus.mem_ack) begin
          if (r_pending || bus.branch_req) begin
            w_redirect     = 1'b1;
            w_redir_target = bus.branch_req ? bus.branch_target : r_pend_target;
            w_state_nxt    = REDIR;
          end else begin
            w_accept    = 1'b1;
            w_state_nxt = HOLD;
          end
        end else if (w_expired) begin
          w_timeout   = 1'b1;
          w_state_nxt = ERR;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      HOLD: begin
        if (bus.branch_req) begin
          w_redirect  = 1'b1;
          w_state_nxt = REDIR;
        end else if (bus.ir_ready) begin
          w_to_fetch  = 1'b1;
          w_state_nxt = FETCH;
        end
      end
      REDIR: begin
        if (bus.branch_req) begin
          w_redirect  = 1'b1;
          w_state_nxt = REDIR;
        end else begin
          w_to_fetch  = 1'b1;
          w_state_nxt = FETCH;
        end
      end
      ERR: begin
        w_state_nxt = ERR;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      r_incr_pc     <= 1'b0;
      r_load        <= 1'b0;
      r_load_addr   <= '0;
      r_mem_req     <= 1'b0;
      r_mem_addr    <= '0;
      r_ir          <= '0;
      r_ir_valid    <= 1'b0;
      r_fetch_err   <= 1'b0;
      r_pending     <= 1'b0;
      r_pend_target <= '0;
    end else begin
      r_incr_pc  <= w_accept;
      r_load     <= w_redirect;
      r_mem_req  <= (w_state_nxt == FETCH);
      r_ir_valid <= (w_state_nxt == HOLD);
      if (w_redirect) begin
        r_load_addr <= w_redir_target;
      end
      if (w_to_fetch) begin
        r_mem_addr <= bus.pc_in;
      end
      if (w_accept) begin
        r_ir <= bus.mem_rdata;
      end
      if (w_timeout) begin
        r_fetch_err <= 1'b1;
      end
      // Last branch during an outstanding fetch wins; flag clears once the fetch resolves.
      r_pending <= (r_state == FETCH) && (w_state_nxt == FETCH) && (r_pending || bus.branch_req);
      if ((r_state == FETCH) && bus.branch_req) begin
        r_pend_target <= bus.branch_target;
      end
    end
  end

  assign bus.incr_pc   = r_incr_pc;
  assign bus.load      = r_load;
  assign bus.load_addr = r_load_addr;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.ir        = r_ir;
  assign bus.ir_valid  = r_ir_valid;
  assign bus.fetch_err = r_fetch_err;

endmodule
`default_nettype wire
